// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: synchronizes and debounces inputs, then moves the
// sprite once per vertical-sync frame in manual (button) or auto (bounce) mode.
`timescale 1ns/1ps
module sprite_motion_ctrl #(
    parameter int unsigned SCREEN_W        = 800,
    parameter int unsigned SCREEN_H        = 600,
    parameter int unsigned SPRITE_SIZE     = 64,
    parameter int unsigned STEP            = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_v_sync,
    input  logic        btn0,
    input  logic        btn1,
    input  logic        btn2,
    input  logic        btn3,
    input  logic        i_mode_auto,
    output logic [15:0] o_sprite_x,
    output logic [15:0] o_sprite_y,
    output logic        o_flip_x,
    output logic        o_flip_y,
    output logic        o_frame_tick
);

    localparam int unsigned MAX_X  = SCREEN_W - SPRITE_SIZE;
    localparam int unsigned MAX_Y  = SCREEN_H - SPRITE_SIZE;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SYNC_W = 6;

    localparam logic [16:0]      MAX_X17  = 17'(MAX_X);
    localparam logic [16:0]      MAX_Y17  = 17'(MAX_Y);
    localparam logic [16:0]      STEP17   = 17'(STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

    // Sync vector layout: {mode, btn3, btn2, btn1, btn0, v_sync}
    logic [SYNC_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]        deb_q, deb_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic              vs_prev_q, vs_prev_d;
    logic [1:0]        sync_vld_q, sync_vld_d;
    logic              armed_q, armed_d;
    logic              frame_evt_c;

    state_t            state_q, state_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic              flip_x_q, flip_x_d, flip_y_q, flip_y_d;
    logic              tick_q, tick_d;

    logic [16:0]       x17, y17, x_up, y_up, x_dn, y_dn;
    logic              x_hit_hi, y_hit_hi, x_hit_lo, y_hit_lo;

    // Synchronizers, debounce and frame-edge detection
    always_comb begin
        sync1_d    = {i_mode_auto, btn3, btn2, btn1, btn0, i_v_sync};
        sync2_d    = sync1_q;
        vs_prev_d  = sync2_q[0];
        sync_vld_d = {sync_vld_q[0], 1'b1};
        // Arm only once a genuine post-reset sample of v_sync has been low
        armed_d    = armed_q | (sync_vld_q[1] & ~sync2_q[0]);
        deb_d      = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i+1] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign frame_evt_c = armed_q & sync2_q[0] & ~vs_prev_q;

    // FSM state register and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            vs_prev_q  <= 1'b0;
            sync_vld_q <= '0;
            armed_q    <= 1'b0;
            state_q    <= MANUAL;
            x_q        <= '0;
            y_q        <= '0;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            flip_x_q   <= 1'b0;
            flip_y_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            vs_prev_q  <= vs_prev_d;
            sync_vld_q <= sync_vld_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            flip_x_q   <= flip_x_d;
            flip_y_q   <= flip_y_d;
            tick_q     <= tick_d;
        end
    end

    // Next state: mode is only sampled at frame events
    always_comb begin
        state_d = state_q;
        if (frame_evt_c) begin
            state_d = sync2_q[5] ? AUTO : MANUAL;
        end
    end

    // Motion: the mode chosen at this frame event drives this same update
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        flip_x_d = flip_x_q;
        flip_y_d = flip_y_q;
        tick_d   = frame_evt_c;

        x17      = {1'b0, x_q};
        y17      = {1'b0, y_q};
        x_up     = x17 + STEP17;
        y_up     = y17 + STEP17;
        x_dn     = x17 - STEP17;
        y_dn     = y17 - STEP17;
        x_hit_hi = (x_up >= MAX_X17);
        y_hit_hi = (y_up >= MAX_Y17);
        x_hit_lo = (x17 <= STEP17);
        y_hit_lo = (y17 <= STEP17);

        if (frame_evt_c) begin
            if (state_d == MANUAL) begin
                if (deb_q[0]) begin
                    x_d      = x_hit_hi ? 16'(MAX_X17) : 16'(x_up);
                    flip_x_d = 1'b0;
                end else if (deb_q[1]) begin
                    x_d      = x_hit_lo ? 16'd0 : 16'(x_dn);
                    flip_x_d = 1'b1;
                end else if (deb_q[2]) begin
                    y_d      = y_hit_hi ? 16'(MAX_Y17) : 16'(y_up);
                    flip_y_d = 1'b0;
                end else if (deb_q[3]) begin
                    y_d      = y_hit_lo ? 16'd0 : 16'(y_dn);
                    flip_y_d = 1'b1;
                end
            end else begin
                if (dir_x_q) begin
                    x_d     = x_hit_hi ? 16'(MAX_X17) : 16'(x_up);
                    dir_x_d = ~x_hit_hi;
                end else begin
                    x_d     = x_hit_lo ? 16'd0 : 16'(x_dn);
                    dir_x_d = x_hit_lo;
                end
                if (dir_y_q) begin
                    y_d     = y_hit_hi ? 16'(MAX_Y17) : 16'(y_up);
                    dir_y_d = ~y_hit_hi;
                end else begin
                    y_d     = y_hit_lo ? 16'd0 : 16'(y_dn);
                    dir_y_d = y_hit_lo;
                end
                flip_x_d = ~dir_x_d;
                flip_y_d = ~dir_y_d;
            end
        end
    end

    assign o_sprite_x   = x_q;
    assign o_sprite_y   = y_q;
    assign o_flip_x     = flip_x_q;
    assign o_flip_y     = flip_y_q;
    assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: expected positions are queued per
// v_sync pulse and checked by a monitor whenever o_frame_tick fires.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        fx;
        logic        fy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v_sync = 1'b0;
    logic        b0 = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
    logic        mode_auto = 1'b0;
    logic [15:0] sx, sy;
    logic        fx, fy, tick;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_cmp = 0;
    int    n_mis = 0;
    int    n_ticks = 0;
    int    n_issued = 0;

    sprite_motion_ctrl #(
        .SCREEN_W(800), .SCREEN_H(600), .SPRITE_SIZE(64),
        .STEP(1), .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync),
        .btn0(b0), .btn1(b1), .btn2(b2), .btn3(b3),
        .i_mode_auto(mode_auto),
        .o_sprite_x(sx), .o_sprite_y(sy),
        .o_flip_x(fx), .o_flip_y(fy), .o_frame_tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d ticks, required %0d", n_ticks, n_issued);
        $fatal(1, "watchdog");
    end

    // Monitor: every tick must match the oldest queued expectation
    always @(negedge clk) begin
        if (tick) begin
            exp_t  e;
            string nm;
            n_ticks++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL unexpected_tick: got tick with x=%0d y=%0d, required no tick", sx, sy);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (sx !== e.x || sy !== e.y || fx !== e.fx || fy !== e.fy) begin
                    n_mis++;
                    $display("FAIL %s: got x=%0d y=%0d fx=%0b fy=%0b, required x=%0d y=%0d fx=%0b fy=%0b",
                             nm, sx, sy, fx, fy, e.x, e.y, e.fx, e.fy);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_mis++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        v_sync = 1'b1;
        cycles(5);
        v_sync = 1'b0;
        cycles(5);
    endtask

    task automatic frame(input int ex, input int ey, input logic efx, input logic efy, input string nm);
        exp_t e;
        e.x  = 16'(ex);
        e.y  = 16'(ey);
        e.fx = efx;
        e.fy = efy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        n_issued++;
        pulse();
    endtask

    task automatic buttons(input logic [3:0] b);
        {b3, b2, b1, b0} = b;
        cycles(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(5);
    endtask

    initial begin
        int ex, ey;

        // Reset values, sampled while reset is still asserted
        rst = 1'b1;
        cycles(4);
        check("rst_x", 32'(sx), 0);
        check("rst_y", 32'(sy), 0);
        check("rst_fx", 32'(fx), 0);
        check("rst_fy", 32'(fy), 0);
        check("rst_tick", 32'(tick), 0);
        rst = 1'b0;
        cycles(5);

        // btn0 held: three frames step right
        buttons(4'b0001);
        frame(1, 0, 1'b0, 1'b0, "btn0_f1");
        frame(2, 0, 1'b0, 1'b0, "btn0_f2");
        frame(3, 0, 1'b0, 1'b0, "btn0_f3");
        buttons(4'b0000);

        // Two-clock glitch must not pass the debouncer
        b0 = 1'b1;
        cycles(2);
        b0 = 1'b0;
        cycles(10);
        frame(3, 0, 1'b0, 1'b0, "glitch_hold");

        buttons(4'b0010);
        frame(2, 0, 1'b1, 1'b0, "btn1_left");
        buttons(4'b1100);
        frame(2, 1, 1'b1, 1'b0, "btn2_over_btn3");
        buttons(4'b1000);
        frame(2, 0, 1'b1, 1'b1, "btn3_up");
        frame(2, 0, 1'b1, 1'b1, "btn3_clamp0");

        // Drive to the right edge, then past it
        buttons(4'b0001);
        for (int k = 3; k <= 736; k++) frame(k, 0, 1'b0, 1'b1, "to_max_x");
        check("at_max_x", 32'(sx), 736);
        frame(736, 0, 1'b0, 1'b1, "clamp_max_x");
        buttons(4'b0011);
        frame(736, 0, 1'b0, 1'b1, "btn0_over_btn1");
        buttons(4'b0000);

        // Reset lands on the frame-update cycle; v_sync stays high after release
        v_sync = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(4);
        check("midrst_x", 32'(sx), 0);
        check("midrst_y", 32'(sy), 0);
        check("midrst_fx", 32'(fx), 0);
        check("midrst_fy", 32'(fy), 0);
        check("midrst_tick", 32'(tick), 0);
        rst = 1'b0;
        cycles(8);
        check("no_tick_after_rst", 32'(n_ticks), 32'(n_issued));
        v_sync = 1'b0;
        cycles(6);

        // Mode change mid-frame takes effect only at the next update
        frame(0, 0, 1'b0, 1'b0, "manual_idle");
        mode_auto = 1'b1;
        cycles(10);
        check("mode_mid_x", 32'(sx), 0);
        check("mode_mid_y", 32'(sy), 0);
        frame(1, 1, 1'b0, 1'b0, "auto_first");
        mode_auto = 1'b0;
        cycles(10);
        check("mode_back_x", 32'(sx), 1);
        frame(1, 1, 1'b0, 1'b0, "manual_hold");
        buttons(4'b0001);
        frame(2, 1, 1'b0, 1'b0, "manual_btn0");
        buttons(4'b0000);

        // Autonomous bounce from reset; held btn1 must be ignored
        mode_auto = 1'b1;
        do_reset();
        buttons(4'b0010);
        for (int k = 1; k <= 737; k++) begin
            ex = (k <= 736) ? k : 1472 - k;
            ey = (k <= 536) ? k : 1072 - k;
            frame(ex, ey, (k >= 736), (k >= 536), "auto_bounce");
            if (k == 536) check("auto_y_peak", 32'(sy), 536);
            if (k == 736) check("auto_x_peak", 32'(sx), 736);
        end
        check("auto_end_x", 32'(sx), 735);
        check("auto_end_fx", 32'(fx), 1);
        check("auto_end_y", 32'(sy), 335);
        buttons(4'b0000);

        cycles(20);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("tick_count", 32'(n_ticks), 32'(n_issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
